// File: rtl/axi_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_pkg
// Shared constants for the AXI3 SRAM slave: burst type codes, response codes,
// FSM state encoding and the request-legality helper.
// ---------------------------------------------------------------------------
package axi_sram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_MEM  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    // Only INCR bursts of at most 32-bit beats are served; anything else is
    // completed with SLVERR and never touches the RAM.
    function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst != BURST_INCR) || (size > 3'd2);
    endfunction

endpackage

// File: rtl/axi_sram_slave_ram.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_ram
// Single-port synchronous RAM, 2^ADDR_WIDTH x 32, per-byte write enables and
// a registered read port. Read data only changes when en is high, so the
// output holds its value for as long as the caller needs it.
// Ports:
//   clk    clock
//   en     read enable (loads rdata from mem[addr])
//   we     per-byte write enables
//   addr   word address
//   wdata  write data
//   rdata  registered read data
// Contents are not reset.
// ---------------------------------------------------------------------------
module axi_sram_slave_ram #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // One byte-wide array per lane keeps each array written from one process.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_q_reg;

        always_ff @(posedge clk) begin
            if (we[gi]) begin
                lane_mem[addr] <= wdata[gi*8 +: 8];
            end
            if (en) begin
                lane_q_reg <= lane_mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = lane_q_reg;
    end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI3 slave backed by an on-chip single-port RAM. One transaction at a time,
// INCR bursts up to 16 beats (longer lengths also work), ID echoed on every
// response, round-robin between read and write requests when both wait.
// Ports:
//   aclk, aresetn                clock, synchronous active-low reset
//   ar*  / arvalid / arready     read request (lock/cache/prot ignored)
//   r*   / rvalid / rready       read data; rdata is 0 on error
//   aw*  / awvalid / awready     write request (lock/cache/prot ignored)
//   w*   / wvalid / wready       write data (wid ignored)
//   b*   / bvalid / bready       write response
// Address bits above ADDR_WIDTH+1 and the byte offset are ignored.
// ---------------------------------------------------------------------------
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    state_t                  state_reg, state_next;
    logic                    last_was_read_reg, last_was_read_next;
    logic [3:0]              id_reg, id_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [7:0]              len_reg, len_next;
    logic [8:0]              beat_reg, beat_next;
    logic                    err_reg, err_next;
    logic [1:0]              bresp_reg, bresp_next;

    logic                    ram_en;
    logic [3:0]              ram_we;
    logic [31:0]             ram_q;
    logic                    is_last_beat;
    logic [8:0]              beat_inc;

    // Sideband fields carry nothing this slave uses.
    logic unused_sideband;
    assign unused_sideband = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                               araddr, awaddr};

    assign is_last_beat = (beat_reg == {1'b0, len_reg});
    // Saturate so a runaway write burst can never wrap back under len.
    assign beat_inc     = (beat_reg == 9'h1FF) ? beat_reg : beat_reg + 9'd1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg         <= ST_IDLE;
            last_was_read_reg <= 1'b0;
            id_reg            <= '0;
            addr_reg          <= '0;
            len_reg           <= '0;
            beat_reg          <= '0;
            err_reg           <= 1'b0;
            bresp_reg         <= RESP_OKAY;
        end else begin
            state_reg         <= state_next;
            last_was_read_reg <= last_was_read_next;
            id_reg            <= id_next;
            addr_reg          <= addr_next;
            len_reg           <= len_next;
            beat_reg          <= beat_next;
            err_reg           <= err_next;
            bresp_reg         <= bresp_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        last_was_read_next = last_was_read_reg;
        id_next            = id_reg;
        addr_next          = addr_reg;
        len_next           = len_reg;
        beat_next          = beat_reg;
        err_next           = err_reg;
        bresp_next         = bresp_reg;
        arready            = 1'b0;
        awready            = 1'b0;
        wready             = 1'b0;
        rvalid             = 1'b0;
        bvalid             = 1'b0;
        ram_en             = 1'b0;
        ram_we             = 4'b0000;

        case (state_reg)
            ST_IDLE: begin
                // Each ready yields only when the other channel is also
                // requesting and it is the other channel's turn, so at most
                // one handshake fires per cycle.
                arready = ~(awvalid & last_was_read_reg);
                awready = ~(arvalid & ~last_was_read_reg);
                if (arvalid && arready) begin
                    id_next            = arid;
                    addr_next          = araddr[ADDR_WIDTH+1:2];
                    len_next           = arlen;
                    beat_next          = '0;
                    err_next           = req_err(arburst, arsize);
                    last_was_read_next = 1'b1;
                    state_next         = ST_RD_MEM;
                end else if (awvalid && awready) begin
                    id_next            = awid;
                    addr_next          = awaddr[ADDR_WIDTH+1:2];
                    len_next           = awlen;
                    beat_next          = '0;
                    err_next           = req_err(awburst, awsize);
                    last_was_read_next = 1'b0;
                    state_next         = ST_WR_DATA;
                end
            end
            ST_RD_MEM: begin
                ram_en     = ~err_reg;
                state_next = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (is_last_beat) begin
                        state_next = ST_IDLE;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        beat_next  = beat_inc;
                        state_next = ST_RD_MEM;
                    end
                end
            end
            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    if (!err_reg && (beat_reg <= {1'b0, len_reg})) begin
                        ram_we = wstrb;
                    end
                    addr_next = addr_reg + 1'b1;
                    beat_next = beat_inc;
                    if (wlast) begin
                        // Beat count at wlast is beat_reg+1; it must equal len+1.
                        bresp_next = (err_reg || !is_last_beat) ? RESP_SLVERR : RESP_OKAY;
                        state_next = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // RAM output only reloads in RD_MEM, so rdata stays stable while stalled.
    assign rdata = (state_reg == ST_RD_DATA && !err_reg) ? ram_q : 32'h0;
    assign rid   = id_reg;
    assign rresp = (state_reg == ST_RD_DATA && err_reg) ? RESP_SLVERR : RESP_OKAY;
    assign rlast = (state_reg == ST_RD_DATA) && is_last_beat;
    assign bid   = id_reg;
    assign bresp = bresp_reg;

    axi_sram_slave_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (aclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_reg),
        .wdata (wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave. Expected R beats and B responses are
// queued from a small memory model when each request is issued and popped as
// the DUT responds.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam int AW    = 16;
    localparam int DEPTH = 1 << AW;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_sram_slave #(.ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'b0000), .arprot(3'b000),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'b0000), .awprot(3'b000),
        .awvalid(awvalid), .awready(awready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    logic [31:0] mem_model [int];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input int w);
        return mem_model.exists(w) ? mem_model[w] : 32'h0;
    endfunction

    // Apply a write to the model and queue the B response it should produce.
    task automatic model_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input int nbeats);
        logic        err;
        int          word;
        int          w;
        logic [31:0] v;
        b_exp_t      be;
        err  = (burst != BURST_INCR) || (size > 3'd2);
        word = int'(addr[AW+1:2]);
        for (int i = 0; i < nbeats; i++) begin
            if (!err && i <= int'(len)) begin
                w = (word + i) % DEPTH;
                v = model_rd(w);
                for (int b = 0; b < 4; b++) begin
                    if (sbuf[i][b]) v[b*8 +: 8] = wbuf[i][b*8 +: 8];
                end
                mem_model[w] = v;
            end
        end
        be.id   = id;
        be.resp = (err || nbeats != int'(len) + 1) ? RESP_SLVERR : RESP_OKAY;
        b_q.push_back(be);
    endtask

    task automatic push_read_exp(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        logic   err;
        int     word;
        r_exp_t re;
        err  = (burst != BURST_INCR) || (size > 3'd2);
        word = int'(addr[AW+1:2]);
        for (int i = 0; i <= int'(len); i++) begin
            re.id   = id;
            re.data = err ? 32'h0 : model_rd((word + i) % DEPTH);
            re.resp = err ? RESP_SLVERR : RESP_OKAY;
            re.last = (i == int'(len));
            r_q.push_back(re);
        end
    endtask

    task automatic collect_b();
        int     n;
        b_exp_t be;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        chk("bvalid", bvalid, 1);
        be = b_q.pop_front();
        bready = 1'b1;
        chk("bid", bid, be.id);
        chk("bresp", bresp, be.resp);
        step();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 0);
        $display("WR done bid=%0d bresp=%0d", bid, bresp);
    endtask

    task automatic write_data_phase(input int nbeats);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            wdata  = wbuf[i];
            wstrb  = sbuf[i];
            wlast  = (i == nbeats - 1);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 20) begin step(); n++; end
            chk("wready", wready, 1);
            step();
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        chk("bvalid_lat", bvalid, 1);
        collect_b();
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int nbeats);
        int n;
        model_write(id, addr, len, burst, size, nbeats);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin step(); n++; end
        chk("awready", awready, 1);
        step();
        awvalid = 1'b0;
        chk("wready_lat", wready, 1);
        $display("WR id=%0d addr=%h len=%0d burst=%0d size=%0d beats=%0d", id, addr, len, burst, size, nbeats);
        write_data_phase(nbeats);
    endtask

    task automatic collect_r(input int nbeats, input bit stall);
        int     n;
        r_exp_t re;
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            while (!rvalid && n < 20) begin step(); n++; end
            chk("rvalid", rvalid, 1);
            re = r_q[0];
            if (stall) begin
                rready = 1'b0;
                step();
                chk("rvalid_hold", rvalid, 1);
                chk("rdata_hold", rdata, re.data);
            end
            rready = 1'b1;
            void'(r_q.pop_front());
            chk("rdata", rdata, re.data);
            chk("rid", rid, re.id);
            chk("rresp", rresp, re.resp);
            chk("rlast", rlast, re.last);
            step();
            rready = 1'b0;
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int n;
        push_read_exp(id, addr, len, size, burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        chk("arready", arready, 1);
        step();
        arvalid = 1'b0;
        chk("rd_mem_rvalid", rvalid, 0);
        collect_r(int'(len) + 1, stall);
        $display("RD id=%0d addr=%h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    // Both request channels rise together; the loser is withdrawn once the
    // winner's handshake has happened.
    task automatic arb_round(input bit exp_read, input logic [31:0] waddr);
        arid = 4'd6; araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
        awid = 4'd7; awaddr = waddr;   awlen = 8'd0; awsize = 3'd2; awburst = BURST_INCR;
        arvalid = 1'b1;
        awvalid = 1'b1;
        #1;
        chk("arb_arready", arready, exp_read);
        chk("arb_awready", awready, !exp_read);
        step();
        arvalid = 1'b0;
        awvalid = 1'b0;
        if (exp_read) begin
            push_read_exp(4'd6, 32'h100, 8'd0, 3'd2, BURST_INCR);
            collect_r(1, 1'b0);
            $display("ARB winner=read");
        end else begin
            wbuf[0] = waddr ^ 32'h5A5A0000;
            sbuf[0] = 4'hF;
            model_write(4'd7, waddr, 8'd0, BURST_INCR, 3'd2, 1);
            $display("ARB winner=write");
            write_data_phase(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        step(); step(); step();

        // Reset state
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rdata",  rdata, 0);
        chk("rst_rid",    rid, 0);
        chk("rst_rresp",  rresp, 0);
        chk("rst_rlast",  rlast, 0);
        chk("rst_bid",    bid, 0);
        chk("rst_bresp",  bresp, 0);
        chk("rst_arready", arready, 1);
        aresetn = 1'b1;
        step();

        // Read with ID echo
        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        do_write(4'd1, 32'h100, 8'd0, BURST_INCR, 3'd2, 1);
        do_read(4'd3, 32'h100, 8'd0, 3'd2, BURST_INCR, 1'b0);

        // Byte strobes then readback
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        do_write(4'd2, 32'h200, 8'd0, BURST_INCR, 3'd2, 1);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(4'd5, 32'h200, 8'd0, BURST_INCR, 3'd2, 1);
        do_read(4'd4, 32'h200, 8'd0, 3'd2, BURST_INCR, 1'b0);
        chk("strobe_model", mem_model[32'h200 >> 2], 32'hFFBBFFDD);

        // INCR burst with read backpressure
        for (int i = 0; i < 4; i++) begin wbuf[i] = i + 1; sbuf[i] = 4'hF; end
        do_write(4'd6, 32'h300, 8'd3, BURST_INCR, 3'd2, 4);
        do_read(4'd7, 32'h300, 8'd3, 3'd2, BURST_INCR, 1'b1);

        // FIXED write is rejected and leaves memory unchanged
        wbuf[0] = 32'h0; sbuf[0] = 4'hF;
        do_write(4'd8, 32'h200, 8'd0, BURST_FIXED, 3'd2, 1);
        do_read(4'd8, 32'h200, 8'd0, 3'd2, BURST_INCR, 1'b0);

        // Oversized read returns SLVERR with zero data
        do_read(4'd9, 32'h200, 8'd0, 3'd3, BURST_INCR, 1'b0);

        // Early wlast: two beats of a four-beat burst
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
        do_write(4'd10, 32'h500, 8'd3, BURST_INCR, 3'd2, 4);
        wbuf[0] = 32'hB0; wbuf[1] = 32'hB1;
        do_write(4'd10, 32'h500, 8'd3, BURST_INCR, 3'd2, 2);
        do_read(4'd10, 32'h500, 8'd3, 3'd2, BURST_INCR, 1'b0);

        // Word address wraps at the top of the RAM; upper bits alias
        wbuf[0] = 32'hC0FFEE01; wbuf[1] = 32'hC0FFEE02; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(4'd11, 32'h0003FFFC, 8'd1, BURST_INCR, 3'd2, 2);
        do_read(4'd11, 32'h0003FFFC, 8'd1, 3'd2, BURST_INCR, 1'b0);
        do_read(4'd12, 32'h00040000, 8'd0, 3'd2, BURST_INCR, 1'b0);

        // Reset while rvalid is held
        push_read_exp(4'd13, 32'h100, 8'd0, 3'd2, BURST_INCR);
        arid = 4'd13; araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        chk("rd_data_rvalid", rvalid, 1);
        aresetn = 1'b0;
        step();
        chk("midrst_rvalid", rvalid, 0);
        r_q.delete();
        aresetn = 1'b1;
        step();
        chk("midrst_arready", arready, 1);
        $display("RST during RD_DATA id=13");

        // Arbitration after reset: read, write, read
        arb_round(1'b1, 32'h600);
        arb_round(1'b0, 32'h604);
        arb_round(1'b1, 32'h608);
        do_read(4'd14, 32'h604, 8'd0, 3'd2, BURST_INCR, 1'b0);

        chk("r_queue_empty", r_q.size(), 0);
        chk("b_queue_empty", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
